// File: rtl/text_cursor_writer.sv
// text_cursor_writer
//   Turns decoded keyboard codes into single-cycle character RAM writes while
//   tracking a row/column text cursor. Supports printable glyphs, newline,
//   backspace with erase, break-prefix suppression and a full-screen clear.
//
// Ports:
//   clk         system clock
//   rst         asynchronous reset, active-low
//   key_code    decoded key code, qualified by key_valid
//   key_valid   one-cycle strobe from the keyboard decoder
//   clear_req   full-screen clear request (level or pulse)
//   busy        high while clear writes are being issued
//   wr_en       character RAM write enable (one-cycle pulse)
//   wr_addr     character RAM write address, row*COLS + col
//   wr_data     character RAM write data
//   cursor_row  current cursor row, 0-based
//   cursor_col  current cursor column, 0-based
module text_cursor_writer #(
  parameter int unsigned       COLS       = 40,
  parameter int unsigned       ROWS       = 15,
  parameter int unsigned       ADDR_W     = 10,
  parameter int unsigned       CODE_W     = 10,
  parameter int unsigned       DATA_W     = 10,
  parameter int unsigned       MAX_CHAR   = 26,
  parameter logic [CODE_W-1:0] BREAK_CODE = CODE_W'('h0F0),
  parameter logic [CODE_W-1:0] ENTER_CODE = CODE_W'('h0C0),
  parameter logic [CODE_W-1:0] BKSP_CODE  = CODE_W'('h108),
  parameter logic [DATA_W-1:0] CLEAR_CHAR = '0,
  localparam int unsigned      ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned      COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] key_code,
  input  logic              key_valid,
  input  logic              clear_req,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [COL_W-1:0]  cursor_col
);

  localparam int unsigned      TOTAL     = ROWS * COLS;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q,    busy_d;
  logic [ROW_W-1:0]  row_q,     row_d;
  logic [COL_W-1:0]  col_q,     col_d;
  logic              ign_q,     ign_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // Neighbouring cursor positions used by the key handlers
  logic [ROW_W-1:0] nl_row;
  logic [ROW_W-1:0] adv_row;
  logic [COL_W-1:0] adv_col;
  logic [ROW_W-1:0] ret_row;
  logic [COL_W-1:0] ret_col;

  // Linear RAM address of a cursor position, computed at full address width
  function automatic logic [ADDR_W-1:0] lin_addr(input logic [ROW_W-1:0] r,
                                                 input logic [COL_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a one-cell screen finishes its clear in the request cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear_req && (TOTAL > 1)) begin
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Next row after a newline, with wrap to the top line
  always_comb begin
    nl_row = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
  end

  // Forward position after a printable write
  always_comb begin
    if (col_q == COL_LAST) begin
      adv_col = '0;
      adv_row = nl_row;
    end else begin
      adv_col = col_q + COL_W'(1);
      adv_row = row_q;
    end
  end

  // Backward position for backspace; (0,0) wraps to the bottom-right cell
  always_comb begin
    if (col_q != '0) begin
      ret_col = col_q - COL_W'(1);
      ret_row = row_q;
    end else begin
      ret_col = COL_LAST;
      ret_row = (row_q == '0) ? ROW_LAST : row_q - ROW_W'(1);
    end
  end

  // Output / datapath next values; address and data hold when no write
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = 1'b0;
    row_d     = row_q;
    col_d     = col_q;
    ign_d     = ign_q;
    clr_cnt_d = clr_cnt_q;

    case (state_q)
      IDLE: begin
        if (clear_req) begin
          // Clear wins over a simultaneous key; address 0 goes out right away
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = CLEAR_CHAR;
          busy_d    = 1'b1;
          clr_cnt_d = ADDR_W'(1);
          if (TOTAL == 1) begin
            row_d = '0;
            col_d = '0;
            ign_d = 1'b0;
          end
        end else if (key_valid) begin
          if (ign_q) begin
            // Code following a break prefix is the released key: swallow it
            ign_d = 1'b0;
          end else if (key_code == BREAK_CODE) begin
            ign_d = 1'b1;
          end else if (key_code == ENTER_CODE) begin
            col_d = '0;
            row_d = nl_row;
          end else if (key_code == BKSP_CODE) begin
            wr_en_d   = 1'b1;
            wr_addr_d = lin_addr(ret_row, ret_col);
            wr_data_d = CLEAR_CHAR;
            row_d     = ret_row;
            col_d     = ret_col;
          end else if (32'(key_code) < MAX_CHAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = lin_addr(row_q, col_q);
            wr_data_d = DATA_W'(key_code);
            row_d     = adv_row;
            col_d     = adv_col;
          end
        end
      end

      CLEAR: begin
        // Keys and further clear requests are ignored while sweeping
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = CLEAR_CHAR;
        busy_d    = 1'b1;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_ADDR) begin
          clr_cnt_d = '0;
          row_d     = '0;
          col_d     = '0;
          ign_d     = 1'b0;
        end
      end

      default: begin
        wr_en_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      ign_q     <= 1'b0;
      clr_cnt_q <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ign_q     <= ign_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign cursor_row = row_q;
  assign cursor_col = col_q;

endmodule
